// File: rtl/music_note_sequencer.sv
// Two-voice song sequencer: walks a synchronous song ROM, decodes note codes to Hz, paced by a beat divider.
// Optional macro STACCATO_GAP_EN silences the outputs during the last 1/8 of each note's final beat.
`default_nettype none

module music_note_sequencer #(
  parameter int CLK_HZ   = 100000000,
  parameter int BEAT_HZ  = 8,
  parameter int ADDR_W   = 8,
  parameter int SONG_LEN = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_play,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_loop,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic [31:0]       o_Rfreq,
  output logic [31:0]       o_Lfreq,
  output logic              o_playing,
  output logic              o_beat,
  output logic              o_done
);

  localparam int DIV   = CLK_HZ / BEAT_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_PAUSE = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [DIV_W-1:0]  div;
  logic [4:0]        beats_left;
  logic [31:0]       rfreq;
  logic [31:0]       lfreq;
  logic              done;
  logic              tick;

  function automatic logic [31:0] note_hz(input logic [5:0] code);
    logic [31:0] base;
    case (code[3:0])
      4'd1:    base = 32'd262;
      4'd2:    base = 32'd277;
      4'd3:    base = 32'd294;
      4'd4:    base = 32'd311;
      4'd5:    base = 32'd330;
      4'd6:    base = 32'd349;
      4'd7:    base = 32'd370;
      4'd8:    base = 32'd392;
      4'd9:    base = 32'd415;
      4'd10:   base = 32'd440;
      4'd11:   base = 32'd466;
      4'd12:   base = 32'd494;
      default: base = 32'd0;
    endcase
    case (code[5:4])
      2'd0:    note_hz = base >> 1;
      2'd1:    note_hz = base;
      2'd2:    note_hz = base << 1;
      default: note_hz = base << 2;
    endcase
  endfunction

  assign tick = (state == S_PLAY) && (div == DIV_LAST) && !i_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr       <= '0;
      div        <= '0;
      beats_left <= '0;
      rfreq      <= '0;
      lfreq      <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (i_stop) begin
        state      <= S_IDLE;
        addr       <= '0;
        div        <= '0;
        beats_left <= '0;
        rfreq      <= '0;
        lfreq      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            div  <= '0;
            addr <= '0;
            if (i_play) state <= S_FETCH;
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD: begin
            div        <= '0;
            rfreq      <= note_hz(i_rom_data[11:6]);
            lfreq      <= note_hz(i_rom_data[5:0]);
            beats_left <= {1'b0, i_rom_data[15:12]} + 5'd1;
            state      <= S_PLAY;
          end
          S_PLAY: begin
            // The pause cycle still counts as played time, so the beat length is preserved.
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
              beats_left <= beats_left - 5'd1;
              // Note end takes priority over a coincident pause.
              if (beats_left == 5'd1) begin
                if (addr != ADDR_LAST) begin
                  addr  <= addr + 1'b1;
                  state <= S_FETCH;
                end else if (i_loop) begin
                  addr  <= '0;
                  state <= S_FETCH;
                end else begin
                  done  <= 1'b1;
                  rfreq <= '0;
                  lfreq <= '0;
                  addr  <= '0;
                  state <= S_IDLE;
                end
              end else if (i_pause) begin
                state <= S_PAUSE;
              end
            end else if (i_pause) begin
              state <= S_PAUSE;
            end
          end
          S_PAUSE: if (i_play) state <= S_PLAY;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef STACCATO_GAP_EN
  localparam logic [31:0] GAP_TH = 32'((7 * DIV + 7) / 8);
  logic gap;
  assign gap = ((state == S_PLAY) || (state == S_PAUSE)) && (beats_left == 5'd1) &&
               (32'(div) >= GAP_TH);
  assign o_Rfreq = gap ? 32'd0 : rfreq;
  assign o_Lfreq = gap ? 32'd0 : lfreq;
`else
  assign o_Rfreq = rfreq;
  assign o_Lfreq = lfreq;
`endif

  assign o_rom_addr = addr;
  assign o_playing  = (state == S_FETCH) || (state == S_LOAD) || (state == S_PLAY);
  assign o_beat     = tick;
  assign o_done     = done;

endmodule

`default_nettype wire

// File: tb/tb_music_note_sequencer.sv
// Scoreboard bench for music_note_sequencer: 8 cycles per beat, 3-word song ROM model.
`default_nettype none

module tb_music_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_play = 1'b0, i_pause = 1'b0, i_stop = 1'b0, i_loop = 1'b0;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic [31:0] o_Rfreq, o_Lfreq;
  logic        o_playing, o_beat, o_done;

  logic [15:0] rom [0:2];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] r;
    logic [31:0] l;
    int          n;
    logic        pl;
    logic [7:0]  addr;
    int          beats;
    int          boff;
    logic        dn;
  } exp_t;
  exp_t sb [$];

  music_note_sequencer #(.CLK_HZ(80), .BEAT_HZ(10), .ADDR_W(8), .SONG_LEN(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_play(i_play), .i_pause(i_pause), .i_stop(i_stop),
    .i_loop(i_loop), .o_rom_addr(o_rom_addr), .i_rom_data(i_rom_data),
    .o_Rfreq(o_Rfreq), .o_Lfreq(o_Lfreq), .o_playing(o_playing), .o_beat(o_beat),
    .o_done(o_done)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk)
    i_rom_data <= (o_rom_addr < 8'd3) ? rom[o_rom_addr[1:0]] : 16'h0000;

  function automatic logic [31:0] ref_hz(input logic [5:0] code);
    logic [31:0] b;
    case (code[3:0])
      4'd1: b = 262;  4'd2: b = 277;  4'd3: b = 294;  4'd4: b = 311;
      4'd5: b = 330;  4'd6: b = 349;  4'd7: b = 370;  4'd8: b = 392;
      4'd9: b = 415;  4'd10: b = 440; 4'd11: b = 466; 4'd12: b = 494;
      default: b = 0;
    endcase
    case (code[5:4])
      2'd0: return b / 2;
      2'd1: return b;
      2'd2: return b * 2;
      default: return b * 4;
    endcase
  endfunction

  task automatic push(input logic [31:0] r, input logic [31:0] l, input int n, input logic pl,
                      input logic [7:0] addr, input int beats, input int boff, input logic dn);
    exp_t e;
    e.r = r; e.l = l; e.n = n; e.pl = pl; e.addr = addr;
    e.beats = beats; e.boff = boff; e.dn = dn;
    sb.push_back(e);
  endtask

  task automatic consume(input string name);
    exp_t e;
    logic eb;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      for (int k = 0; k < e.n; k++) begin
        @(negedge clk);
        eb = (e.beats > 0) && (k < e.beats * 8 - e.boff) && (((k + e.boff) % 8) == 7);
        checks++;
        if (o_Rfreq !== e.r || o_Lfreq !== e.l || o_playing !== e.pl ||
            o_rom_addr !== e.addr || o_beat !== eb || o_done !== e.dn) begin
          errors++;
          $display("FAIL %s k=%0d: got R=%0d L=%0d addr=%0d playing=%b beat=%b done=%b, expected R=%0d L=%0d addr=%0d playing=%b beat=%b done=%b",
                   name, k, o_Rfreq, o_Lfreq, o_rom_addr, o_playing, o_beat, o_done,
                   e.r, e.l, e.addr, e.pl, eb, e.dn);
        end
      end
    end
  endtask

  // Pulses start at a negedge and drop just after the sampling edge.
  task automatic pulse(input logic p, input logic pa, input logic st);
    i_play = p; i_pause = pa; i_stop = st;
    @(posedge clk);
    #1;
    i_play = 1'b0; i_pause = 1'b0; i_stop = 1'b0;
  endtask

  task automatic load_song();
    rom[0] = 16'h0450;
    rom[1] = 16'h1861;
    rom[2] = 16'h0FFF;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (o_Rfreq !== 0 || o_Lfreq !== 0 || o_rom_addr !== 0 || o_playing !== 0 ||
        o_beat !== 0 || o_done !== 0) begin
      errors++;
      $display("FAIL reset: got R=%0d L=%0d addr=%0d playing=%b beat=%b done=%b, expected all 0",
               o_Rfreq, o_Lfreq, o_rom_addr, o_playing, o_beat, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 3, 0, 0, 0, 0, 0);
    consume("reset_idle");
  endtask

  task automatic test_play_song();
    i_loop = 1'b0;
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 8, 1, 0, 1, 0, 0);
    push(262, 0, 2, 1, 1, 0, 0, 0);
    push(524, 524, 16, 1, 1, 2, 0, 0);
    push(524, 524, 2, 1, 2, 0, 0, 0);
    push(0, 0, 8, 1, 2, 1, 0, 0);
    push(0, 0, 1, 0, 0, 0, 0, 1);
    push(0, 0, 3, 0, 0, 0, 0, 0);
    consume("play_song");
  endtask

  task automatic test_loop();
    i_loop = 1'b1;
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 8, 1, 0, 1, 0, 0);
    push(262, 0, 2, 1, 1, 0, 0, 0);
    push(524, 524, 16, 1, 1, 2, 0, 0);
    push(524, 524, 2, 1, 2, 0, 0, 0);
    push(0, 0, 8, 1, 2, 1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 8, 1, 0, 1, 0, 0);
    consume("loop");
    pulse(0, 0, 1);
    i_loop = 1'b0;
    push(0, 0, 3, 0, 0, 0, 0, 0);
    consume("loop_stop");
  endtask

  task automatic test_pause();
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 4, 1, 0, 1, 0, 0);
    consume("pause_pre");
    pulse(0, 1, 0);
    push(262, 0, 20, 0, 0, 0, 0, 0);
    consume("pause_hold");
    pulse(1, 0, 0);
    push(262, 0, 4, 1, 0, 1, 4, 0);
    push(262, 0, 2, 1, 1, 0, 0, 0);
    push(524, 524, 3, 1, 1, 2, 0, 0);
    consume("pause_resume");
    pulse(0, 0, 1);
    push(0, 0, 2, 0, 0, 0, 0, 0);
    consume("pause_stop");
  endtask

  task automatic test_simultaneous();
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 8, 1, 0, 1, 0, 0);
    push(262, 0, 2, 1, 1, 0, 0, 0);
    push(524, 524, 5, 1, 1, 2, 0, 0);
    consume("simul_pre");
    pulse(1, 1, 1);
    push(0, 0, 4, 0, 0, 0, 0, 0);
    consume("simul_stop");
  endtask

  task automatic test_decoder_sweep();
    logic [5:0] rc, lc;
    for (int c = 0; c < 64; c++) begin
      rc = 6'(c);
      lc = 6'(63 - c);
      rom[0] = {4'h0, rc, lc};
      pulse(1, 0, 0);
      push(0, 0, 2, 1, 0, 0, 0, 0);
      push(ref_hz(rc), ref_hz(lc), 1, 1, 0, 1, 0, 0);
      consume("decoder");
      pulse(0, 0, 1);
      push(0, 0, 1, 0, 0, 0, 0, 0);
      consume("decoder_stop");
    end
  endtask

  task automatic test_async_reset();
    load_song();
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 3, 1, 0, 1, 0, 0);
    consume("areset_pre");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (o_Rfreq !== 0 || o_Lfreq !== 0 || o_rom_addr !== 0 || o_playing !== 0 ||
        o_beat !== 0 || o_done !== 0) begin
      errors++;
      $display("FAIL async_reset: got R=%0d L=%0d addr=%0d playing=%b beat=%b done=%b, expected all 0",
               o_Rfreq, o_Lfreq, o_rom_addr, o_playing, o_beat, o_done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 0, 2, 0, 0, 0, 0, 0);
    consume("areset_idle");
    pulse(1, 0, 0);
    push(0, 0, 2, 1, 0, 0, 0, 0);
    push(262, 0, 8, 1, 0, 1, 0, 0);
    push(262, 0, 2, 1, 1, 0, 0, 0);
    consume("areset_restart");
    pulse(0, 0, 1);
    push(0, 0, 1, 0, 0, 0, 0, 0);
    consume("areset_stop");
  endtask

  initial begin
    load_song();
    test_reset();
    test_play_song();
    test_loop();
    test_pause();
    test_simultaneous();
    test_decoder_sweep();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/music_note_sequencer.md
Name: music_note_sequencer

Overview:
Song playback sequencer. Steps through a song ROM of two-voice note words and converts each note code to a frequency in Hz. Drives the 32-bit right-hand and left-hand frequency buses consumed by the LED bar decoder and the tone generators. Timing comes from an internal beat divider. Play, pause and stop are driven by debounced button pulses.

Parameters:
CLK_HZ, 100000000, system clock frequency
BEAT_HZ, 8, beat ticks per second (one tick = one duration unit)
ADDR_W, 8, song ROM address width
SONG_LEN, 128, number of note words in the song (1..2^ADDR_W)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_play  in  1  one-cycle pulse: start from IDLE, or resume from PAUSE
i_pause  in  1  one-cycle pulse: freeze playback
i_stop  in  1  one-cycle pulse: abort and return to IDLE
i_loop  in  1  level: restart at address 0 after the last note
o_rom_addr  out  ADDR_W  song ROM address (ROM read is synchronous, 1-cycle latency)
i_rom_data  in  16  ROM word: [15:12] duration-1 in beats, [11:6] right note code, [5:0] left note code
o_Rfreq  out  32  right-voice frequency in Hz; 0 = rest
o_Lfreq  out  32  left-voice frequency in Hz; 0 = rest
o_playing  out  1  high in FETCH/LOAD/PLAY
o_beat  out  1  one-cycle pulse on each beat tick
o_done  out  1  one-cycle pulse at song end when not looping

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. On reset all outputs are 0, state is IDLE, and the beat divider and beat count are 0.
- Note code [5:4] = octave, [3:0] = pitch.
  - Pitch 1..12 maps to C4..B4: 262, 277, 294, 311, 330, 349, 370, 392, 415, 440, 466, 494.
  - Octave 0 = base>>1, 1 = base, 2 = base<<1, 3 = base<<2.
  - Pitch 0 or 13..15 = rest, giving frequency 0.
  - Examples: 0x01 -> 131, 0x11 -> 262, 0x21 -> 524, 0x32 -> 1108.
- Divider: counts 0..CLK_HZ/BEAT_HZ-1 and emits a tick on wrap.
  - Runs only in PLAY.
  - Holds its value in PAUSE.
  - Clears in IDLE and LOAD.
- State machine:
  - IDLE: o_rom_addr = 0, freqs = 0. i_play -> FETCH.
  - FETCH: ROM access for one cycle -> LOAD.
  - LOAD: capture i_rom_data, decode and register o_Rfreq/o_Lfreq, load beats_left = dur+1 -> PLAY.
  - PLAY: on each tick, pulse o_beat and decrement beats_left. At 0:
    - If the address is not SONG_LEN-1: increment the address -> FETCH.
    - Else if i_loop: address = 0 -> FETCH.
    - Else: pulse o_done, clear freqs, address = 0 -> IDLE.
  - PAUSE: all counters and outputs hold. i_play -> PLAY.
- Latency: i_play sampled on edge N puts new freqs on the bus after edge N+2. Between notes the previous frequencies hold through FETCH/LOAD (2-cycle gap, no glitch to 0).
- Simultaneous pulses: i_stop wins over i_pause, which wins over i_play.
  - i_stop in any state: freqs = 0, address = 0, IDLE on the next edge, no o_done.
  - i_pause outside PLAY is ignored. i_play in PLAY/FETCH/LOAD is ignored.
- o_playing is low in PAUSE.
- Asserting rst_n mid-note clears everything immediately (asynchronous).

Optional Feature:
Macro STACCATO_GAP_EN.
- Defined: during the final beat of each note, once the divider is at or above 7/8 of its period, o_Rfreq/o_Lfreq read 0. The registered values are kept and restore on the next LOAD. This articulates repeated notes.
- Undefined: frequencies are held for the full note duration.

Test Plan:
All scenarios use CLK_HZ=80, BEAT_HZ=10 (8 cycles/beat) and SONG_LEN=3.
1. ROM = {0x0450 (1 beat, R=0x11, L=0x10), 0x1861 (2 beats, R=0x21, L=0x21), 0x0FFF}; pulse i_play -> o_Rfreq=262, o_Lfreq=0 two edges later; 8 cycles later, after a 2-cycle gap, R=L=524 for 16 cycles; then R=L=0 (rest code 15); then o_done pulse, IDLE, o_playing=0.
2. Same song with i_loop=1 -> after the third note, o_rom_addr returns to 0, R=262 again, and o_done never pulses.
3. Pause at cycle 4 of a beat for 20 cycles, then i_play -> freqs and o_beat frozen during the pause; the next o_beat arrives 4 cycles after resume.
4. i_play, i_pause and i_stop pulsed together while in PLAY -> IDLE, freqs=0, addr=0, no o_done.
5. Decoder sweep: each octave 0..3 × pitch 0..15 -> exact table values (e.g. 0x3C -> 1976, 0x0E -> 0).
6. rst_n low mid-note -> all outputs 0 asynchronously; after release, an i_play restarts at address 0.
